// File: rtl/jtag_dap_pkg.sv
// Shared types and opcode helpers for the multi-channel JTAG debug access port.
package jtag_dap_pkg;

  typedef enum logic [3:0] {
    TLR       = 4'h0,
    RTI       = 4'h1,
    SEL_DR    = 4'h2,
    CAP_DR    = 4'h3,
    SHIFT_DR  = 4'h4,
    EXIT1_DR  = 4'h5,
    PAUSE_DR  = 4'h6,
    EXIT2_DR  = 4'h7,
    UPD_DR    = 4'h8,
    SEL_IR    = 4'h9,
    CAP_IR    = 4'hA,
    SHIFT_IR  = 4'hB,
    EXIT1_IR  = 4'hC,
    PAUSE_IR  = 4'hD,
    EXIT2_IR  = 4'hE,
    UPD_IR    = 4'hF
  } tap_state_e;

  localparam int OP_IDCODE = 1;
  // Truncated to the IR width this becomes the all-ones opcode.
  localparam int OP_BYPASS = -1;

  function automatic int ch_opcode(input int base, input int k);
    return base + k;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller: state register, next-state logic and decoded action strobes.
module jtag_tap_fsm
  import jtag_dap_pkg::*;
(
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output tap_state_e state,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr,
  output logic       capture_ir,
  output logic       shift_ir,
  output logic       update_ir,
  output logic       tlr
);

  tap_state_e nxt;

  // NOTE: every branch assigns nxt after a default, so no latch is inferred.
  always_comb begin
    nxt = state;
    unique case (state)
      TLR:      nxt = tms ? TLR      : RTI;
      RTI:      nxt = tms ? SEL_DR   : RTI;
      SEL_DR:   nxt = tms ? SEL_IR   : CAP_DR;
      CAP_DR:   nxt = tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: nxt = tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: nxt = tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: nxt = tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: nxt = tms ? UPD_DR   : SHIFT_DR;
      UPD_DR:   nxt = tms ? SEL_DR   : RTI;
      SEL_IR:   nxt = tms ? TLR      : CAP_IR;
      CAP_IR:   nxt = tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: nxt = tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: nxt = tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: nxt = tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: nxt = tms ? UPD_IR   : SHIFT_IR;
      UPD_IR:   nxt = tms ? SEL_DR   : RTI;
      default:  nxt = TLR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample together.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) state <= TLR;
    else      state <= nxt;
  end

  // Strobes mark the edge on which the current state's action takes effect.
  assign capture_dr = (state == CAP_DR);
  assign shift_dr   = (state == SHIFT_DR);
  assign update_dr  = (state == UPD_DR);
  assign capture_ir = (state == CAP_IR);
  assign shift_ir   = (state == SHIFT_IR);
  assign update_ir  = (state == UPD_IR);
  assign tlr        = (nxt == TLR);

endmodule

// File: rtl/jtag_dap_multi.sv
// JTAG debug access port: one TAP, IDCODE/BYPASS and NCH scan channels with update strobes.
module jtag_dap_multi
  import jtag_dap_pkg::*;
#(
  parameter int          IRW     = 4,
  parameter int          DRW     = 32,
  parameter int          NCH     = 4,
  parameter logic [31:0] IDCODE  = 32'h1DC0_0001,
  parameter int          CH_BASE = 2
) (
  input  logic               tck,
  input  logic               trst,
  input  logic               tdi,
  input  logic               tms,
  output logic               tdo,
  output logic               tdo_en,
  output logic [IRW-1:0]     ir_q,
  input  logic [NCH*DRW-1:0] dr_capture_data,
  output logic [DRW-1:0]     dr_update_data,
  output logic [NCH-1:0]     dr_update_valid
);

  localparam logic [IRW-1:0] OP_IDC = IRW'(OP_IDCODE);
  localparam logic [IRW-1:0] OP_BYP = IRW'(OP_BYPASS);
  localparam logic [IRW-1:0] IR_CAPTURE = {{(IRW-2){1'b0}}, 2'b01};

  tap_state_e state;
  logic capture_dr, shift_dr, update_dr;
  logic capture_ir, shift_ir, update_ir;
  logic tlr;

  jtag_tap_fsm u_fsm (
    .tck        (tck),
    .trst       (trst),
    .tms        (tms),
    .state      (state),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr),
    .capture_ir (capture_ir),
    .shift_ir   (shift_ir),
    .update_ir  (update_ir),
    .tlr        (tlr)
  );

  logic [IRW-1:0] ir_sr;
  logic [31:0]    idcode_sr;
  logic           bypass_sr;
  logic [DRW-1:0] ch_sr [NCH];

  logic           sel_idcode;
  logic           sel_bypass;
  logic [NCH-1:0] sel_ch;
  logic           dr_bit0;
  logic [DRW-1:0] ch_sel_sr;

  // Any opcode that is neither IDCODE nor a channel (including 0 and all-ones) means BYPASS.
  always_comb begin
    sel_idcode = (ir_q == OP_IDC);
    for (int k = 0; k < NCH; k++) begin
      sel_ch[k] = (ir_q == IRW'(ch_opcode(CH_BASE, k)));
    end
    sel_bypass = (ir_q == OP_BYP) || !(sel_idcode || (|sel_ch));
  end

  always_comb begin
    dr_bit0   = bypass_sr;
    ch_sel_sr = '0;
    if (sel_idcode) dr_bit0 = idcode_sr[0];
    for (int k = 0; k < NCH; k++) begin
      if (sel_ch[k]) begin
        dr_bit0   = ch_sr[k][0];
        ch_sel_sr = ch_sr[k];
      end
    end
  end

  assign tdo_en = shift_ir | shift_dr;

  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      ir_q            <= OP_IDC;
      ir_sr           <= '0;
      idcode_sr       <= '0;
      bypass_sr       <= 1'b0;
      dr_update_data  <= '0;
      dr_update_valid <= '0;
      tdo             <= 1'b0;
      for (int k = 0; k < NCH; k++) ch_sr[k] <= '0;
    end else begin
      dr_update_valid <= '0;

      if (capture_ir)    ir_sr <= IR_CAPTURE;
      else if (shift_ir) ir_sr <= {tdi, ir_sr[IRW-1:1]};

      if (tlr)            ir_q <= OP_IDC;
      else if (update_ir) ir_q <= ir_sr;

      if (capture_dr) begin
        if (sel_idcode) idcode_sr <= IDCODE;
        if (sel_bypass) bypass_sr <= 1'b0;
        for (int k = 0; k < NCH; k++) begin
          if (sel_ch[k]) ch_sr[k] <= dr_capture_data[k*DRW +: DRW];
        end
      end else if (shift_dr) begin
        if (sel_idcode) idcode_sr <= {tdi, idcode_sr[31:1]};
        if (sel_bypass) bypass_sr <= tdi;
        for (int k = 0; k < NCH; k++) begin
          if (sel_ch[k]) ch_sr[k] <= {tdi, ch_sr[k][DRW-1:1]};
        end
      end

      if (update_dr && (|sel_ch)) begin
        dr_update_data  <= ch_sel_sr;
        dr_update_valid <= sel_ch;
      end

      // tdo presents the bit leaving the register on this shift edge.
      if (shift_ir)      tdo <= ir_sr[0];
      else if (shift_dr) tdo <= dr_bit0;
    end
  end

endmodule

// File: tb/tb_jtag_dap_multi.sv
// Scoreboard-driven bench for jtag_dap_multi: tdo bits are queued as driven and checked on return.
module tb_jtag_dap_multi;
  import jtag_dap_pkg::*;

  logic         tck = 1'b0;
  logic         trst, tdi, tms;
  logic         tdo, tdo_en;
  logic [3:0]   ir_q;
  logic [127:0] dr_capture_data;
  logic [31:0]  dr_update_data;
  logic [3:0]   dr_update_valid;

  int n_checks = 0;
  int n_errors = 0;
  logic exp_q[$];

  jtag_dap_multi dut (
    .tck             (tck),
    .trst            (trst),
    .tdi             (tdi),
    .tms             (tms),
    .tdo             (tdo),
    .tdo_en          (tdo_en),
    .ir_q            (ir_q),
    .dr_capture_data (dr_capture_data),
    .dr_update_data  (dr_update_data),
    .dr_update_valid (dr_update_valid)
  );

  always #5 tck = ~tck;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic tms_v, input logic tdi_v);
    @(negedge tck);
    tms = tms_v;
    tdi = tdi_v;
    @(posedge tck);
    #1;
  endtask

  // Shift n bits LSB-first; the last one leaves the shift state when do_exit is set.
  task automatic shift_bits(input string tag, input int n, input logic [63:0] din,
                            input logic [63:0] dout, input bit do_exit);
    logic e;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(dout[i]);
      step(do_exit && (i == n - 1), din[i]);
      e = exp_q.pop_front();
      check($sformatf("%s_tdo[%0d]", tag, i), 64'(tdo), 64'(e));
    end
    if (do_exit) check({tag, "_tdo_en_off"}, 64'(tdo_en), 64'h0);
  endtask

  task automatic rti_to_shift_dr();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("shift_dr_tdo_en", 64'(tdo_en), 64'h1);
  endtask

  task automatic load_ir(input logic [3:0] v);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("shift_ir_tdo_en", 64'(tdo_en), 64'h1);
    shift_bits("ir", 4, 64'(v), 64'h1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("ir_q_loaded", 64'(ir_q), 64'(v));
  endtask

  // From Exit1-DR: go through Update-DR to Run-Test/Idle and check the strobe window.
  task automatic update_and_check(input string tag, input logic [3:0] exp_valid,
                                  input logic [31:0] exp_data, input bit data_valid);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check({tag, "_valid"}, 64'(dr_update_valid), 64'(exp_valid));
    if (data_valid) check({tag, "_data"}, 64'(dr_update_data), 64'(exp_data));
    step(1'b0, 1'b0);
    check({tag, "_valid_drop"}, 64'(dr_update_valid), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    trst = 1'b1;
    tms = 1'b1;
    tdi = 1'b0;
    dr_capture_data = '0;
    repeat (3) @(negedge tck);
    check("rst_tdo", 64'(tdo), 64'h0);
    check("rst_tdo_en", 64'(tdo_en), 64'h0);
    check("rst_ir_q", 64'(ir_q), 64'h1);
    check("rst_valid", 64'(dr_update_valid), 64'h0);
    check("rst_data", 64'(dr_update_data), 64'h0);
    check("rst_state", 64'(dut.u_fsm.state), 64'(TLR));
    trst = 1'b0;

    // IDCODE read out LSB-first
    step(1'b0, 1'b0);
    rti_to_shift_dr();
    shift_bits("idcode", 32, 64'h0, 64'h1DC0_0001, 1'b1);
    update_and_check("idcode_upd", 4'b0000, 32'h0, 1'b0);

    // Explicit BYPASS opcode echoes tdi one tck late
    load_ir(4'hF);
    rti_to_shift_dr();
    shift_bits("bypass_f", 4, 64'b1101, 64'b1010, 1'b1);
    update_and_check("bypass_f_upd", 4'b0000, 32'h0, 1'b0);

    // Reserved opcode 0 acts as BYPASS
    load_ir(4'h0);
    rti_to_shift_dr();
    shift_bits("bypass_0", 3, 64'b011, 64'b110, 1'b1);
    update_and_check("bypass_0_upd", 4'b0000, 32'h0, 1'b0);

    // Channel 2 full read/write
    dr_capture_data[2*32 +: 32] = 32'hDEAD_BEEF;
    load_ir(4'h4);
    rti_to_shift_dr();
    shift_bits("ch2", 32, 64'h1234_5678, 64'hDEAD_BEEF, 1'b1);
    update_and_check("ch2_upd", 4'b0100, 32'h1234_5678, 1'b1);

    // Channel 0 zero-shift write-back of the captured value
    dr_capture_data[0 +: 32] = 32'hA5A5_A5A5;
    load_ir(4'h2);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    update_and_check("ch0_upd", 4'b0001, 32'hA5A5_A5A5, 1'b1);

    // Channel 3 overshift: capture falls out first, last 32 tdi bits win
    dr_capture_data[3*32 +: 32] = 32'h0BAD_F00D;
    load_ir(4'h5);
    rti_to_shift_dr();
    shift_bits("ch3_over", 40, 64'hCA_FEF0_0D5A, {24'h0, 8'h5A, 32'h0BAD_F00D}, 1'b1);
    update_and_check("ch3_upd", 4'b1000, 32'hCAFE_F00D, 1'b1);

    // trst during a channel-1 shift aborts without a strobe
    dr_capture_data[1*32 +: 32] = 32'h1357_9BDF;
    load_ir(4'h3);
    rti_to_shift_dr();
    shift_bits("ch1_part", 10, 64'h3FF, 64'h1357_9BDF, 1'b0);
    #2;
    trst = 1'b1;
    #1;
    check("abort_ir_q", 64'(ir_q), 64'h1);
    check("abort_state", 64'(dut.u_fsm.state), 64'(TLR));
    check("abort_tdo_en", 64'(tdo_en), 64'h0);
    check("abort_tdo", 64'(tdo), 64'h0);
    check("abort_data", 64'(dr_update_data), 64'h0);
    @(negedge tck);
    trst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1);
      check("abort_no_strobe", 64'(dr_update_valid), 64'h0);
    end
    check("abort_ir_q_after", 64'(ir_q), 64'h1);

    // Five tms=1 from Pause-DR reach TLR and restore IDCODE
    load_ir(4'h3);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("pause_state", 64'(dut.u_fsm.state), 64'(PAUSE_DR));
    check("pause_ir_q", 64'(ir_q), 64'h3);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    check("tlr_state", 64'(dut.u_fsm.state), 64'(TLR));
    check("tlr_ir_q", 64'(ir_q), 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
